// File: rtl/synth_pkg.sv
// Shared constants, note encoding and FSM state type for the note finder and
// any note/frequency helper blocks.
package synth_pkg;

    localparam logic [6:0]  NUM_NOTES        = 7'd108;
    localparam logic [6:0]  LAST_IDX         = 7'd107;
    localparam logic [6:0]  NOTES_PER_OCTAVE = 7'd12;
    localparam logic [15:0] MIN_FREQ         = 16'd16;
    localparam logic [15:0] MAX_FREQ         = 16'd7902;

    typedef enum logic [3:0] {
        NOTE_C, NOTE_CS, NOTE_D, NOTE_DS, NOTE_E, NOTE_F,
        NOTE_FS, NOTE_G, NOTE_GS, NOTE_A, NOTE_AS, NOTE_B
    } note_e;

    typedef enum logic [2:0] {
        IDLE, SEARCH, REFINE, DIVIDE, DONE
    } state_e;

    // 17-bit difference so neither 0 nor 65535 wraps into a false "small" distance
    function automatic logic [16:0] dist17(input logic [15:0] a, input logic [15:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

endpackage

// File: rtl/note_table_rom.sv
// Equal-tempered note table, index = octave*12 + note, C0..B8 rounded to whole Hz.
// Indices past the last note read as 65535 so searches treat them as "too high".
module note_table_rom
    import synth_pkg::*;
(
    input  logic [6:0]  idx_i,
    output logic [15:0] hz_o
);

    localparam logic [15:0] HZ_TABLE [108] = '{
        16'd16,   16'd17,   16'd18,   16'd19,   16'd21,   16'd22,   16'd23,   16'd24,   16'd26,   16'd28,   16'd29,   16'd31,
        16'd33,   16'd35,   16'd37,   16'd39,   16'd41,   16'd44,   16'd46,   16'd49,   16'd52,   16'd55,   16'd58,   16'd62,
        16'd65,   16'd69,   16'd73,   16'd78,   16'd82,   16'd87,   16'd92,   16'd98,   16'd104,  16'd110,  16'd117,  16'd123,
        16'd131,  16'd139,  16'd147,  16'd156,  16'd165,  16'd175,  16'd185,  16'd196,  16'd208,  16'd220,  16'd233,  16'd247,
        16'd262,  16'd277,  16'd294,  16'd311,  16'd330,  16'd349,  16'd370,  16'd392,  16'd415,  16'd440,  16'd466,  16'd494,
        16'd523,  16'd554,  16'd587,  16'd622,  16'd659,  16'd698,  16'd740,  16'd784,  16'd831,  16'd880,  16'd932,  16'd988,
        16'd1047, 16'd1109, 16'd1175, 16'd1245, 16'd1319, 16'd1397, 16'd1480, 16'd1568, 16'd1661, 16'd1760, 16'd1865, 16'd1976,
        16'd2093, 16'd2217, 16'd2349, 16'd2489, 16'd2637, 16'd2794, 16'd2960, 16'd3136, 16'd3322, 16'd3520, 16'd3729, 16'd3951,
        16'd4186, 16'd4435, 16'd4699, 16'd4978, 16'd5274, 16'd5588, 16'd5920, 16'd6272, 16'd6645, 16'd7040, 16'd7459, 16'd7902
    };

    assign hz_o = (idx_i < NUM_NOTES) ? HZ_TABLE[idx_i] : 16'hFFFF;

endmodule

// File: rtl/note_finder.sv
// Nearest-note finder: 7-step binary search, one refine step, then repeated
// subtraction into note/octave. Define NOTE_FINDER_DETUNE_EN for the detune output.
module note_finder
    import synth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] frequency,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  note,
    output logic [3:0]  octave,
    output logic        out_of_range
`ifdef NOTE_FINDER_DETUNE_EN
    ,
    output logic signed [15:0] detune
`endif
);

    state_e      state_q, state_d;
    logic [15:0] freq_q, freq_d;
    logic [6:0]  idx_q, idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  oct_q, oct_d;
    logic        oor_q, oor_d;
    logic [6:0]  cand, rom_a_idx, rom_b_idx;
    logic [15:0] tab_a, tab_b;
    logic        lo_clamp, hi_clamp, step_up;

    assign cand      = idx_q | (7'd1 << bit_q);
    assign rom_a_idx = (state_q == SEARCH) ? cand : idx_q;
    assign rom_b_idx = idx_q + 7'd1;

    note_table_rom u_rom_a (.idx_i(rom_a_idx), .hz_o(tab_a));
    note_table_rom u_rom_b (.idx_i(rom_b_idx), .hz_o(tab_b));

    assign lo_clamp = freq_q < MIN_FREQ;
    assign hi_clamp = freq_q > MAX_FREQ;
    // equal distances keep the lower note
    assign step_up  = (idx_q < LAST_IDX) && (dist17(tab_b, freq_q) < dist17(freq_q, tab_a));

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        oct_d   = oct_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEARCH;
                    freq_d  = frequency;
                    idx_d   = 7'd0;
                    bit_d   = 3'd6;
                    oct_d   = 4'd0;
                end
            end
            SEARCH: begin
                if ((cand < NUM_NOTES) && (tab_a <= freq_q)) idx_d = cand;
                if (bit_q == 3'd0) state_d = REFINE;
                else               bit_d   = bit_q - 3'd1;
            end
            REFINE: begin
                state_d = DIVIDE;
                oor_d   = lo_clamp || hi_clamp;
                if (lo_clamp)      idx_d = 7'd0;
                else if (hi_clamp) idx_d = LAST_IDX;
                else if (step_up)  idx_d = idx_q + 7'd1;
            end
            DIVIDE: begin
                if (idx_q >= NOTES_PER_OCTAVE) begin
                    idx_d = idx_q - NOTES_PER_OCTAVE;
                    oct_d = oct_q + 4'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            oct_q   <= 4'd0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oct_q   <= oct_d;
            oor_q   <= oor_d;
        end
    end

    always_ff @(posedge clk) begin
        freq_q <= freq_d;
        bit_q  <= bit_d;
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign note         = idx_q[3:0];
    assign octave       = oct_q;
    assign out_of_range = oor_q;

`ifdef NOTE_FINDER_DETUNE_EN
    logic signed [15:0] det_q, det_d;
    logic [15:0]        sel_hz;

    always_comb begin
        sel_hz = tab_a;
        if (lo_clamp)      sel_hz = MIN_FREQ;
        else if (hi_clamp) sel_hz = MAX_FREQ;
        else if (step_up)  sel_hz = tab_b;
        det_d = det_q;
        if (state_q == REFINE) det_d = $signed(freq_q - sel_hz);
    end

    always_ff @(posedge clk) begin
        if (reset) det_q <= '0;
        else       det_q <= det_d;
    end

    assign detune = det_q;
`endif

endmodule

// File: tb/tb_note_finder.sv
// Randomized bench for note_finder against a nearest-note model built from the
// equal-tempered formula; build with NOTE_FINDER_DETUNE_EN to also check detune.
module tb_note_finder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] frequency = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  note;
    logic [3:0]  octave;
    logic        out_of_range;
`ifdef NOTE_FINDER_DETUNE_EN
    logic signed [15:0] detune;
`endif

    always #5 clk = ~clk;

    note_finder dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .frequency(frequency),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .note(note),
        .octave(octave),
        .out_of_range(out_of_range)
`ifdef NOTE_FINDER_DETUNE_EN
        ,
        .detune(detune)
`endif
    );

    typedef struct {
        int note;
        int octave;
        int oor;
        int det;
        int lat;
    } res_t;

    int   tbl [108];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   tmo_cnt = 0;
    int   tmo_seen = 0;
    int   due = 0;
    bit   pending = 1'b0;
    bit   rst_chk = 1'b0;
    bit   pins_done = 1'b0;
    res_t exp_r;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void build_table();
        for (int i = 0; i < 108; i++) begin
            real r;
            r = 440.0 * $pow(2.0, (real'(i) - 57.0) / 12.0);
            tbl[i] = $rtoi(r + 0.5);
        end
    endfunction

    // nearest table entry by absolute distance, first (lower) one wins a tie
    function automatic res_t model(input int f);
        res_t r;
        int best = 0;
        int d_best;
        logic [15:0] d16;
        d_best = (f > tbl[0]) ? f - tbl[0] : tbl[0] - f;
        for (int i = 1; i < 108; i++) begin
            int d;
            d = (f > tbl[i]) ? f - tbl[i] : tbl[i] - f;
            if (d < d_best) begin
                d_best = d;
                best   = i;
            end
        end
        r.note   = best % 12;
        r.octave = best / 12;
        r.oor    = (f < 16 || f > 7902) ? 1 : 0;
        d16      = 16'(f - tbl[best]);
        r.det    = int'($signed(d16));
        r.lat    = 9 + r.octave;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!pins_done) begin
            res_t p;
            pins_done = 1'b1;
            chk("tbl_C0", tbl[0], 16);
            chk("tbl_A4", tbl[57], 440);
            chk("tbl_B8", tbl[107], 7902);
            p = model(440);
            chk("pin440_note", p.note, 9);
            chk("pin440_oct", p.octave, 4);
            chk("pin440_det", p.det, 0);
            chk("pin440_lat", p.lat, 13);
            p = model(453);
            chk("pin453_note", p.note, 9);
            chk("pin453_det", p.det, 13);
            p = model(454);
            chk("pin454_note", p.note, 10);
            chk("pin454_det", p.det, -12);
            p = model(0);
            chk("pin0_oor", p.oor, 1);
            chk("pin0_note", p.note, 0);
            p = model(9000);
            chk("pin9000_note", p.note, 11);
            chk("pin9000_oct", p.octave, 8);
            chk("pin9000_det", p.det, 1098);
        end
        if (tmo_cnt != tmo_seen) begin
            tmo_seen = tmo_cnt;
            miscompares++;
        end
        if (!reset) begin
            bit exp_ov;
            if (rst_chk) begin
                chk("rst_note", int'(note), 0);
                chk("rst_octave", int'(octave), 0);
                chk("rst_oor", int'(out_of_range), 0);
`ifdef NOTE_FINDER_DETUNE_EN
                chk("rst_detune", int'(detune), 0);
`endif
            end
            chk("in_ready", int'(in_ready), pending ? 0 : 1);
            exp_ov = pending && (cyc >= due);
            chk("out_valid", int'(out_valid), int'(exp_ov));
            if (exp_ov && out_valid) begin
                chk("note", int'(note), exp_r.note);
                chk("octave", int'(octave), exp_r.octave);
                chk("out_of_range", int'(out_of_range), exp_r.oor);
`ifdef NOTE_FINDER_DETUNE_EN
                chk("detune", int'(detune), exp_r.det);
`endif
            end
        end
    end

    task automatic accept(input int f, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            $display("FAIL accept_wait: in_ready stuck low, required high within 50 cycles");
            tmo_cnt++;
            ok = 1'b0;
            return;
        end
        #1;
        in_valid  = 1'b1;
        frequency = 16'(f);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        exp_r     = model(f);
        due       = cyc + exp_r.lat;
        pending   = 1'b1;
        frequency = 16'($urandom);
        ok        = 1'b1;
    endtask

    task automatic collect(input int hold, input bit poke);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            $display("FAIL result_wait: out_valid low, required high within 40 cycles");
            tmo_cnt++;
            pending = 1'b0;
            return;
        end
        for (int k = 0; k < hold; k++) begin
            #1;
            in_valid  = poke;
            frequency = 16'd1000;
            @(negedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        pending   = 1'b0;
    endtask

    task automatic run(input int f, input int hold, input bit poke, input bit early);
        bit ok;
        accept(f, ok);
        if (!ok) return;
        if (early) begin
            @(negedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
            #1 out_ready = 1'b0;
        end
        collect(hold, poke);
    endtask

    task automatic pulse_reset(input int n);
        #1;
        reset   = 1'b1;
        pending = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        rst_chk  = 1'b1;
        @(negedge clk);
        #1 rst_chk = 1'b0;
    endtask

    initial begin
        bit ok;
        int f;
        build_table();
        // reset must win over a simultaneous request
        in_valid  = 1'b1;
        frequency = 16'd440;
        pulse_reset(2);

        run(440, 0, 1'b0, 1'b0);
        run(453, 1, 1'b0, 1'b0);
        run(454, 0, 1'b0, 1'b1);
        run(0, 2, 1'b0, 1'b0);
        run(9000, 0, 1'b0, 1'b0);
        run(440, 20, 1'b1, 1'b0);

        accept(262, ok);
        repeat (3) @(posedge clk);
        pulse_reset(1);
        repeat (20) @(negedge clk);
        run(262, 0, 1'b0, 1'b0);

        run(15, 0, 1'b0, 1'b0);
        run(16, 0, 1'b0, 1'b0);
        run(7902, 0, 1'b0, 1'b0);
        run(7903, 1, 1'b0, 1'b0);
        run(65535, 0, 1'b0, 1'b0);

        for (int t = 0; t < 80; t++) begin
            int i;
            case ($urandom_range(0, 5))
                0: f = int'($urandom_range(0, 8200));
                1: begin
                    i = int'($urandom_range(0, 107));
                    f = tbl[i] + int'($urandom_range(0, 6)) - 3;
                    if (f < 0) f = 0;
                end
                2: begin
                    i = int'($urandom_range(0, 106));
                    f = (tbl[i] + tbl[i + 1]) / 2 + int'($urandom_range(0, 1));
                end
                3: f = int'($urandom_range(0, 20));
                4: f = int'($urandom_range(7890, 7915));
                default: f = int'($urandom_range(8000, 65535));
            endcase
            run(f, int'($urandom_range(0, 3)), 1'b0, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_finder.md
NOTE_FINDER -- requirements
Module: note_finder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 in_valid  input  1  frequency request present.
REQ-004 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-005 frequency  input  16  measured frequency in whole Hz, unsigned.
REQ-006 out_valid  output  1  result present; held until accepted.
REQ-007 out_ready  input  1  consumer accepts result.
REQ-008 note  output  4  nearest note, 0=C .. 11=B.
REQ-009 octave  output  4  octave of nearest note, 0..8.
REQ-010 out_of_range  output  1  input below 16 Hz or above 7902 Hz; result clamped.
REQ-011 detune  output  16  signed, frequency minus table frequency of chosen note; present only with NOTE_FINDER_DETUNE_EN.

Function
REQ-012 Table: 108 entries, index i = octave*12 + note, equal-tempered frequency rounded to Hz, C0=16 .. B8=7902, monotonic non-decreasing.
REQ-013 FSM states IDLE, SEARCH, REFINE, DIVIDE, DONE; IDLE->SEARCH on in_valid && in_ready, frequency latched that cycle.
REQ-014 SEARCH: binary search over 7-bit index space, exactly 7 cycles; indices 108..127 compare as greater than any input; result = largest i with TABLE[i] <= frequency, or 0 if none.
REQ-015 REFINE (1 cycle): if i<107 and (TABLE[i+1]-frequency) < (frequency-TABLE[i]) then i=i+1; tie keeps lower index.
REQ-016 Clamp: frequency<16 -> i=0, out_of_range=1; frequency>7902 -> i=107, out_of_range=1; otherwise out_of_range=0.
REQ-017 DIVIDE: subtract 12 per cycle while remainder>=12, incrementing octave; takes octave+1 cycles; note=remainder.
REQ-018 DONE: out_valid=1 with note, octave, out_of_range, detune stable; DONE->IDLE on out_ready; out_valid deasserts next cycle.
REQ-019 Latency acceptance-to-out_valid = 9 + octave cycles; max 17.
REQ-020 in_valid ignored outside IDLE; no queuing; back-to-back requests separated by at least one IDLE cycle.
REQ-021 out_ready outside DONE ignored.
REQ-022 All arithmetic unsigned 17-bit for distance comparisons; no overflow at 0 or 65535.

Reset
REQ-023 reset forces IDLE, in_ready=1, out_valid=0, note=0, octave=0, out_of_range=0, detune=0 on next edge.
REQ-024 reset asserted mid-SEARCH/DIVIDE/DONE aborts request; no result emitted; reset dominates simultaneous in_valid.

Configuration
REQ-025 NOTE_FINDER_DETUNE_EN defined: detune port present, computed in REFINE as frequency minus TABLE[final i], sign-extended.
REQ-026 NOTE_FINDER_DETUNE_EN undefined: detune port and its register absent; all other behaviour and latency identical.

Structure
REQ-027 Shared package synth_pkg holds NUM_NOTES=108, NOTES_PER_OCTAVE=12, MIN_FREQ=16, MAX_FREQ=7902, note encoding constants, FSM state typedef.
REQ-028 Sub-module note_table_rom: combinational 7-bit index -> 16-bit Hz, returns 65535 for index>=108; reusable by note-to-frequency path.

Verification
REQ-029 frequency=440 -> note=9, octave=4, out_of_range=0, out_valid 13 cycles after acceptance, detune=0.
REQ-030 frequency=453 (tie 440/466) -> note=9, octave=4, detune=+13; frequency=454 -> note=10, octave=4, detune=-12.
REQ-031 frequency=0 -> note=0, octave=0, out_of_range=1; frequency=9000 -> note=11, octave=8, out_of_range=1, detune=+1098.
REQ-032 out_ready held low 20 cycles in DONE -> outputs stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-033 reset pulsed 3 cycles after accepting 262 -> no out_valid, in_ready=1 next cycle; then 262 -> note=0, octave=4.
